// File: rtl/seg_scan_controller.sv
// Scan sequencer for a 4-digit 7-segment display: prescaled scan counter, registered
// active-low anodes, and a frame-synchronous commit buffer for bytes from the UART.
module seg_scan_controller #(
  parameter int CLK_DIV = 20000
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       enable,
  input  logic       rx_valid,
  input  logic [7:0] rx_data,
  output logic [3:0] counter,
  output logic [7:0] data_out,
  output logic [3:0] anode,
  output logic       frame_done,
  output logic       pending,
  output logic       overrun,
  output logic [1:0] dbg_state
);

  // rx_valid is a single-cycle strobe with no ready: the byte is always accepted,
  // and a byte lost to a later strobe is flagged through overrun.
  typedef enum logic [1:0] {IDLE = 2'd0, SCAN = 2'd1, STOP = 2'd2} state_t;

  localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

  state_t      state_q, state_d;
  logic [15:0] presc_q, presc_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [3:0]  anode_q, anode_d;
  logic [7:0]  data_q, data_d;
  logic [7:0]  buf_q, buf_d;
  logic        pending_q, pending_d;
  logic        overrun_q, overrun_d;
  logic        frame_done_q;
  logic        tick, boundary, commit;

  assign tick     = (state_q != IDLE) && (presc_q == DIV_LAST);
  assign boundary = tick && (cnt_q == 4'hF);
  // While idle nothing is being shown, so a waiting byte can go straight out.
  assign commit   = (state_q == IDLE) ? pending_q : boundary;

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    anode_d   = 4'hF;
    data_d    = data_q;
    buf_d     = buf_q;
    pending_d = pending_q;
    overrun_d = overrun_q;

    case (state_q)
      IDLE: begin
        presc_d = 16'd0;
        cnt_d   = 4'd0;
        if (enable) state_d = SCAN;
      end
      SCAN: begin
        if (!enable) state_d = STOP;
      end
      STOP: begin
        if (boundary)    state_d = IDLE;
        else if (enable) state_d = SCAN;
      end
      default: state_d = IDLE;
    endcase

    if (state_q != IDLE) begin
      presc_d = tick ? 16'd0 : presc_q + 16'd1;
      cnt_d   = tick ? cnt_q + 4'd1 : cnt_q;
    end

    // Anodes follow the current counter one clock late to line up with the char generator.
    if (state_q != IDLE && cnt_q[1:0] != 2'd3) anode_d = ~(4'b1000 >> cnt_q[3:2]);

    if (commit && pending_q) begin
      data_d    = buf_q;
      pending_d = 1'b0;
    end
    if (rx_valid) begin
      buf_d     = rx_data;
      pending_d = 1'b1;
      if (pending_q && !commit) overrun_d = 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q      <= IDLE;
      presc_q      <= 16'd0;
      cnt_q        <= 4'd0;
      anode_q      <= 4'hF;
      data_q       <= 8'h00;
      buf_q        <= 8'h00;
      pending_q    <= 1'b0;
      overrun_q    <= 1'b0;
      frame_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      presc_q      <= presc_d;
      cnt_q        <= cnt_d;
      anode_q      <= anode_d;
      data_q       <= data_d;
      buf_q        <= buf_d;
      pending_q    <= pending_d;
      overrun_q    <= overrun_d;
      frame_done_q <= boundary;
    end
  end

  assign counter    = cnt_q;
  assign data_out   = data_q;
  assign anode      = anode_q;
  assign frame_done = frame_done_q;
  assign pending    = pending_q;
  assign overrun    = overrun_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_seg_scan_controller.sv
// Bench for seg_scan_controller: directed scenarios plus random traffic, every cycle
// compared against a frame-time reference model.
module tb_seg_scan_controller;

  localparam int DIV   = 4;
  localparam int FRAME = 16 * DIV;

  logic       clock = 1'b0;
  logic       reset;
  logic       enable;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [3:0] counter;
  logic [7:0] data_out;
  logic [3:0] anode;
  logic       frame_done;
  logic       pending;
  logic       overrun;
  logic [1:0] dbg_state;

  seg_scan_controller #(.CLK_DIV(DIV)) dut (
    .clock(clock), .reset(reset), .enable(enable), .rx_valid(rx_valid), .rx_data(rx_data),
    .counter(counter), .data_out(data_out), .anode(anode), .frame_done(frame_done),
    .pending(pending), .overrun(overrun), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clock = ~clock;

  int checks   = 0;
  int failures = 0;

  // Reference model: m_mode 0=idle 1=scanning 2=stopping; m_t = clocks since scan start.
  int         m_mode;
  int         m_t;
  logic [3:0] e_anode;
  logic [7:0] e_data, e_buf;
  logic       e_pend, e_ovr, e_fd;
  logic [7:0] exp_q[$];
  logic [3:0] dmask[4] = '{4'b0111, 4'b1011, 4'b1101, 4'b1110};

  function automatic int exp_counter();
    return (m_mode == 0) ? 0 : (m_t / DIV) % 16;
  endfunction

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_clock();
    int   c;
    logic bnd, com, np;
    if (reset) begin
      m_mode = 0; m_t = 0; e_anode = 4'hF; e_data = 8'h00; e_buf = 8'h00;
      e_pend = 1'b0; e_ovr = 1'b0; e_fd = 1'b0;
      exp_q.delete();
      return;
    end
    c       = exp_counter();
    bnd     = (m_mode != 0) && ((m_t % FRAME) == FRAME - 1);
    e_anode = (m_mode == 0 || (c % 4) == 3) ? 4'hF : dmask[c / 4];
    com     = (m_mode == 0) ? e_pend : bnd;
    e_fd    = bnd;
    np      = e_pend;
    if (com && e_pend) begin
      e_data = e_buf;
      exp_q.push_back(e_buf);
      np = 1'b0;
    end
    if (rx_valid) begin
      if (e_pend && !com) e_ovr = 1'b1;
      e_buf = rx_data;
      np    = 1'b1;
    end
    e_pend = np;
    if (m_mode == 0) begin
      if (enable) begin m_mode = 1; m_t = 0; end
    end else begin
      m_t++;
      if (m_mode == 2 && bnd) m_mode = 0;
      else m_mode = enable ? 1 : 2;
    end
  endtask

  // scoreboard
  task automatic check_all();
    logic [7:0] v;
    chk("counter", {4'h0, counter}, 8'(exp_counter()));
    chk("anode", {4'h0, anode}, {4'h0, e_anode});
    chk("data_out", data_out, e_data);
    chk("frame_done", {7'h0, frame_done}, {7'h0, e_fd});
    chk("pending", {7'h0, pending}, {7'h0, e_pend});
    chk("overrun", {7'h0, overrun}, {7'h0, e_ovr});
    chk("state", {6'h0, dbg_state}, 8'(m_mode));
    while (exp_q.size() > 0) begin
      v = exp_q.pop_front();
      chk("commit", data_out, v);
    end
  endtask

  // drivers
  task automatic step();
    @(posedge clock);
    model_clock();
    #1;
    check_all();
  endtask

  task automatic send(input logic [7:0] d);
    rx_valid = 1'b1;
    rx_data  = d;
    step();
    rx_valid = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  // Advance until the next clock edge will see frame position ph (counter = ph/DIV).
  task automatic wait_phase(input int ph);
    int n;
    bit ok;
    n = 0;
    while (!(m_mode != 0 && (m_t % FRAME) == ph) && n < 4 * FRAME) begin
      step();
      n++;
    end
    ok = (n < 4 * FRAME);
    checks++;
    assert (ok) else begin
      failures++;
      $error("FAIL wait_phase_%0d observed=timeout expected=reached", ph);
    end
  endtask

  initial begin
    int n;
    reset = 1'b1; enable = 1'b0; rx_valid = 1'b0; rx_data = 8'h00;
    m_mode = 0; m_t = 0; e_anode = 4'hF; e_data = 8'h00; e_buf = 8'h00;
    e_pend = 1'b0; e_ovr = 1'b0; e_fd = 1'b0;
    step();
    step();
    reset = 1'b0;
    step();
    chk("reset_anode", {4'h0, anode}, 8'h0F);

    // T1: free scan with no data
    enable = 1'b1;
    for (int i = 0; i < 2 * FRAME + 5; i++) step();
    chk("t1_data", data_out, 8'h00);

    // T2: single byte shown at the next wrap
    wait_phase(5 * DIV);
    send(8'hA5);
    chk("t2_pending", {7'h0, pending}, 8'h01);
    wait_phase(FRAME - 1);
    step();
    chk("t2_data", data_out, 8'hA5);
    chk("t2_fd", {7'h0, frame_done}, 8'h01);
    chk("t2_pend0", {7'h0, pending}, 8'h00);

    // T3: two bytes in one frame
    wait_phase(2 * DIV);
    send(8'h12);
    wait_phase(9 * DIV);
    send(8'h34);
    chk("t3_ovr", {7'h0, overrun}, 8'h01);
    wait_phase(FRAME - 1);
    step();
    chk("t3_data", data_out, 8'h34);
    step();
    chk("t3_ovr_sticky", {7'h0, overrun}, 8'h01);

    // T4: strobe on the boundary clock
    do_reset();
    step();
    wait_phase(3 * DIV);
    send(8'h66);
    wait_phase(FRAME - 1);
    send(8'h77);
    chk("t4_data", data_out, 8'h66);
    chk("t4_pend", {7'h0, pending}, 8'h01);
    chk("t4_ovr", {7'h0, overrun}, 8'h00);
    wait_phase(FRAME - 1);
    step();
    chk("t4_data2", data_out, 8'h77);
    chk("t4_pend2", {7'h0, pending}, 8'h00);

    // T5: stop, idle commit, restart
    wait_phase(6 * DIV);
    enable = 1'b0;
    n = 0;
    while (m_mode != 0 && n < 2 * FRAME) begin step(); n++; end
    step();
    chk("t5_anode", {4'h0, anode}, 8'h0F);
    chk("t5_counter", {4'h0, counter}, 8'h00);
    send(8'h5C);
    chk("t5_pend", {7'h0, pending}, 8'h01);
    step();
    chk("t5_data", data_out, 8'h5C);
    enable = 1'b1;
    step();
    for (int i = 0; i < DIV; i++) step();
    chk("t5_restart", {4'h0, counter}, 8'h01);

    // T6: reset mid-frame with pending and overrun set
    wait_phase(4);
    send(8'h01);
    send(8'h02);
    wait_phase(9 * DIV);
    do_reset();
    chk("t6_counter", {4'h0, counter}, 8'h00);
    chk("t6_anode", {4'h0, anode}, 8'h0F);
    chk("t6_data", data_out, 8'h00);
    chk("t6_flags", {5'h0, frame_done, pending, overrun}, 8'h00);
    chk("t6_state", {6'h0, dbg_state}, 8'h00);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 99) < 3) enable = ~enable;
      rx_valid = ($urandom_range(0, 19) == 0);
      rx_data  = 8'($urandom);
      reset    = ($urandom_range(0, 599) == 0);
      step();
    end
    reset = 1'b0; rx_valid = 1'b0;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
